// File: rtl/lcd_spi_sequencer.sv
// Command-queue sequencer feeding a byte-level SPI controller for an LCD.
// Queues SEND / DELAY / SETRST commands and issues them one at a time.
module lcd_spi_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int DELAY_UNIT = 1000,
    parameter int TIMEOUT    = 4096
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_kind,
    input  logic                              cmd_dc,
    input  logic [7:0]                        cmd_data,
    input  logic                              flush,
    input  logic                              err_clear,
    output logic                              spi_start,
    output logic [7:0]                        spi_data,
    output logic                              spi_dc,
    input  logic                              spi_busy,
    input  logic                              spi_done,
    output logic                              lcd_rst_n,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
    output logic                              seq_idle,
    output logic                              err_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = $clog2(255 * DELAY_UNIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] DU_L    = DW'(DELAY_UNIT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

    localparam logic [1:0] K_SEND   = 2'b00;
    localparam logic [1:0] K_DELAY  = 2'b01;
    localparam logic [1:0] K_SETRST = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY
    } state_t;

    state_t state, state_next;

    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_next;
    logic          full, empty, push, pop;

    logic [10:0]   head;
    logic [1:0]    head_kind;
    logic          head_dc;
    logic [7:0]    head_data;

    logic [DW-1:0] delay_cnt;
    logic [TW-1:0] to_cnt;
    logic          latch_send, load_delay, set_rst, set_err;

    // spi_busy is informational only; the done pulse alone ends a transfer.
    logic unused_busy;
    assign unused_busy = spi_busy;

    // A command transfers on any cycle with cmd_valid && cmd_ready; cmd_ready
    // never looks at cmd_valid and is low whenever full or flushing.
    assign full      = (level == DEPTH_L);
    assign empty     = (level == '0);
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;

    assign head      = mem[rd_ptr];
    assign head_kind = head[10:9];
    assign head_dc   = head[8];
    assign head_data = head[7:0];

    assign fifo_level = level;
    assign spi_start  = (state == S_ISSUE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_kind, cmd_dc, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_next;
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        latch_send = 1'b0;
        load_delay = 1'b0;
        set_rst    = 1'b0;
        set_err    = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !flush) begin
                    pop = 1'b1;
                    case (head_kind)
                        K_SEND: begin
                            latch_send = 1'b1;
                            state_next = S_ISSUE;
                        end
                        K_DELAY: begin
                            if (head_data != 8'd0) begin
                                load_delay = 1'b1;
                                state_next = S_DELAY;
                            end
                        end
                        K_SETRST: set_rst = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_ISSUE: state_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (spi_done) begin
                    state_next = S_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    set_err    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DELAY: begin
                if (flush || delay_cnt == DW'(1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (flush) begin
            level_next = '0;
        end else begin
            level_next = level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            spi_data    <= 8'd0;
            spi_dc      <= 1'b0;
            lcd_rst_n   <= 1'b0;
            err_timeout <= 1'b0;
            delay_cnt   <= '0;
            to_cnt      <= '0;
            seq_idle    <= 1'b1;
        end else begin
            state <= state_next;
            if (latch_send) begin
                spi_data <= head_data;
                spi_dc   <= head_dc;
            end
            if (set_rst) lcd_rst_n <= head_data[0];
            // Full-width product: the DELAY state lasts exactly count*DELAY_UNIT cycles.
            if (load_delay) begin
                delay_cnt <= DW'(head_data) * DU_L;
            end else if (state == S_DELAY) begin
                delay_cnt <= delay_cnt - DW'(1);
            end
            if (state == S_ISSUE) begin
                to_cnt <= '0;
            end else if (state == S_WAIT_DONE) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (set_err) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
            seq_idle <= (state_next == S_IDLE) && (level_next == '0);
        end
    end

endmodule
